// File: rtl/vlog_seq_shifter_if.sv
// Start/busy/done handshake bundle for the sequential shifter.
// master drives the request side, slave is the shift unit.
interface vlog_seq_shifter_if #(
  parameter int WIDTH = 9,
  parameter int AMT_W = 4
);
  logic             start;
  logic [1:0]       mode;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] din;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dout;

  modport master (output start, mode, amt, din, input busy, done, dout);
  modport slave  (input start, mode, amt, din, output busy, done, dout);
endinterface

// File: rtl/vlog_seq_shifter.sv
// Multi-cycle SLL/SRL/SLA/SRA unit shifting up to STEP bits per clock.
// Latency ceil(min(amt,WIDTH)/STEP)+1 cycles; start is ignored outside IDLE.
module vlog_seq_shifter #(
  parameter int WIDTH = 9,
  parameter int AMT_W = 4,
  parameter int STEP  = 1
) (
  input logic clk,
  input logic rst,
  vlog_seq_shifter_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] work, work_nxt, dout_q;
  logic [CNT_W-1:0] rem, rem_nxt, eff, k;
  logic [1:0]       mode_q;
  logic             sign_q;
  logic             load;
  logic [AMT_W-1:0] amt_v;

  assign amt_v = bus.amt;

  // Shift amounts at or beyond WIDTH saturate to a full-width shift.
  always_comb begin
    if (32'(amt_v) >= 32'(WIDTH)) eff = CNT_W'(WIDTH);
    else                          eff = CNT_W'(amt_v);
  end

  assign k = (rem < CNT_W'(STEP)) ? rem : CNT_W'(STEP);

  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] v,
                                                input logic [1:0] m,
                                                input logic s,
                                                input logic [CNT_W-1:0] n);
    logic [WIDTH-1:0] fill;
    logic [WIDTH-1:0] r;
    fill = ~({WIDTH{1'b1}} >> n);
    case (m)
      2'b01:   r = v >> n;
      2'b11:   r = (v >> n) | (s ? fill : '0);
      default: r = v << n;
    endcase
    return r;
  endfunction

  always_comb begin
    state_nxt = state;
    work_nxt  = work;
    rem_nxt   = rem;
    load      = 1'b0;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          work_nxt  = bus.din;
          rem_nxt   = eff;
          state_nxt = (eff == '0) ? FINISH : SHIFT;
        end
      end
      SHIFT: begin
        bus.busy  = 1'b1;
        work_nxt  = shift_by(work, mode_q, sign_q, k);
        rem_nxt   = rem - k;
        if (rem == k) state_nxt = FINISH;
      end
      FINISH: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // dout is loaded on the edge into FINISH so it is already valid while done is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work   <= '0;
      rem    <= '0;
      mode_q <= 2'b00;
      sign_q <= 1'b0;
      dout_q <= '0;
    end else begin
      work <= work_nxt;
      rem  <= rem_nxt;
      if (load) begin
        mode_q <= bus.mode;
        sign_q <= bus.din[WIDTH-1];
      end
      if (state_nxt == FINISH && state != FINISH) dout_q <= work_nxt;
    end
  end

  assign bus.dout = dout_q;
endmodule

// File: tb/tb_vlog_seq_shifter.sv
// Bench for vlog_seq_shifter: a 9-bit STEP=1 and a 16-bit STEP=4 instance,
// directed vectors, handshake corner sequences and randomized model checks.
module tb_vlog_seq_shifter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vlog_seq_shifter_if #(.WIDTH(9),  .AMT_W(4)) ia();
  vlog_seq_shifter_if #(.WIDTH(16), .AMT_W(5)) ib();

  vlog_seq_shifter #(.WIDTH(9),  .AMT_W(4), .STEP(1)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  vlog_seq_shifter #(.WIDTH(16), .AMT_W(5), .STEP(4)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          which;
    logic [1:0]  mode;
    int          amt;
    logic [15:0] din;
    logic [31:0] exp_dout;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int which, input logic s, input logic [1:0] m,
                       input logic [4:0] a, input logic [15:0] d);
    if (which == 0) begin
      ia.start = s; ia.mode = m; ia.amt = a[3:0]; ia.din = d[8:0];
    end else begin
      ib.start = s; ib.mode = m; ib.amt = a; ib.din = d;
    end
  endtask

  function automatic logic [31:0] get_busy(input int which);
    return (which == 0) ? {31'b0, ia.busy} : {31'b0, ib.busy};
  endfunction
  function automatic logic [31:0] get_done(input int which);
    return (which == 0) ? {31'b0, ia.done} : {31'b0, ib.done};
  endfunction
  function automatic logic [31:0] get_dout(input int which);
    return (which == 0) ? {23'b0, ia.dout} : {16'b0, ib.dout};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: shift as integer arithmetic (multiply / divide by 2^eff).
  function automatic logic [31:0] model(input int w, input logic [1:0] m, input int a, input logic [15:0] d);
    int     eff  = (a > w) ? w : a;
    longint mask = (longint'(1) << w) - 1;
    longint v    = longint'(d) & mask;
    longint r;
    case (m)
      2'b01: r = v / (longint'(1) << eff);
      2'b11: begin
        if (((v >> (w - 1)) & 1) != 0) v = v - (longint'(1) << w);
        r = v >>> eff;
      end
      default: r = v * (longint'(1) << eff);
    endcase
    return 32'(r & mask);
  endfunction

  function automatic int lat_model(input int w, input int s, input int a);
    int eff = (a > w) ? w : a;
    return (eff == 0) ? 1 : (eff + s - 1) / s + 1;
  endfunction

  task automatic run_op(input int which, input logic [1:0] m, input int a, input logic [15:0] d,
                        output logic [31:0] dout_got, output int lat, output int busy_cnt);
    drive(which, 1'b1, m, 5'(a), d);
    lat = -1;
    busy_cnt = 0;
    dout_got = '0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (c == 1) drive(which, 1'b0, 2'($urandom), 5'($urandom), 16'($urandom));
      if (get_done(which) == 1) begin
        lat = c;
        dout_got = get_dout(which);
        break;
      end
      if (get_busy(which) == 1) busy_cnt++;
    end
    if (lat < 0) begin
      check("op_timeout", 32'(lat), 32'(lat_model(which == 0 ? 9 : 16, which == 0 ? 1 : 4, a)));
    end else begin
      step();
      check("done_one_cycle", get_done(which), 32'd0);
      check("dout_hold", get_dout(which), dout_got);
    end
  endtask

  initial begin
    logic [31:0] got;
    int lat, bcnt, c, ndone;
    int done_at[$];
    logic [31:0] dout_at[$];

    vecs[0] = '{0, 2'b00,  3, 16'h00FF, 32'h1F8,  4};
    vecs[1] = '{0, 2'b11,  4, 16'h0100, 32'h1F0,  5};
    vecs[2] = '{0, 2'b01,  4, 16'h0100, 32'h010,  5};
    vecs[3] = '{0, 2'b11, 15, 16'h01AA, 32'h1FF, 10};
    vecs[4] = '{0, 2'b00, 15, 16'h01AA, 32'h000, 10};
    vecs[5] = '{1, 2'b01, 10, 16'hF000, 32'h003C, 4};
    vecs[6] = '{1, 2'b11, 17, 16'h8001, 32'hFFFF, 5};
    vecs[7] = '{1, 2'b11,  5, 16'h8000, 32'hFC00, 3};
    vecs[8] = '{0, 2'b00,  0, 16'h00AB, 32'h0AB,  1};
    vecs[9] = '{0, 2'b10,  2, 16'h01AA, 32'h0A8,  3};

    drive(0, 1'b0, 2'b00, 5'd0, 16'h0);
    drive(1, 1'b0, 2'b00, 5'd0, 16'h0);
    #1;
    for (int w = 0; w < 2; w++) begin
      check($sformatf("reset_busy%0d", w), get_busy(w), 32'd0);
      check($sformatf("reset_done%0d", w), get_done(w), 32'd0);
      check($sformatf("reset_dout%0d", w), get_dout(w), 32'd0);
    end
    repeat (2) step();
    rst = 1'b0;
    step();

    foreach (vecs[i]) begin
      run_op(vecs[i].which, vecs[i].mode, vecs[i].amt, vecs[i].din, got, lat, bcnt);
      check($sformatf("vec%0d_dout", i), got, vecs[i].exp_dout);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_busy", i), 32'(bcnt), 32'(vecs[i].exp_lat - 1));
    end

    // Reset in the middle of a shift: outputs clear at once and no done follows.
    drive(0, 1'b1, 2'b00, 5'd5, 16'h00AB);
    step();
    drive(0, 1'b0, 2'b00, 5'd5, 16'h00AB);
    step();
    check("mid_busy", get_busy(0), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_busy", get_busy(0), 32'd0);
    check("rst_done", get_done(0), 32'd0);
    check("rst_dout", get_dout(0), 32'd0);
    step();
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (get_done(0) == 1) ndone++;
    end
    check("rst_no_done", 32'(ndone), 32'd0);

    // A start pulse while busy must be ignored.
    drive(0, 1'b1, 2'b00, 5'd4, 16'h0003);
    step();
    drive(0, 1'b0, 2'b00, 5'd4, 16'h0003);
    step();
    drive(0, 1'b1, 2'b01, 5'd1, 16'h01FF);
    step();
    drive(0, 1'b0, 2'b00, 5'd0, 16'h0000);
    lat = -1;
    got = '0;
    for (c = 4; c <= 40; c++) begin
      step();
      if (get_done(0) == 1) begin
        lat = c;
        got = get_dout(0);
        break;
      end
    end
    check("busy_start_lat", 32'(lat), 32'd5);
    check("busy_start_dout", got, 32'h030);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (get_done(0) == 1) ndone++;
    end
    check("busy_start_not_queued", 32'(ndone), 32'd0);

    // start held high: second accept on the cycle after done.
    drive(0, 1'b1, 2'b00, 5'd2, 16'h0001);
    for (c = 1; c <= 20; c++) begin
      step();
      if (c == 1) drive(0, 1'b1, 2'b00, 5'd2, 16'h0003);
      if (c == 4) check("held_idle_gap_busy", get_busy(0), 32'd0);
      if (get_done(0) == 1) begin
        done_at.push_back(c);
        dout_at.push_back(get_dout(0));
        if (done_at.size() == 2) break;
      end
    end
    drive(0, 1'b0, 2'b00, 5'd0, 16'h0000);
    check("held_done_count", 32'(done_at.size()), 32'd2);
    if (done_at.size() == 2) begin
      check("held_first_at", 32'(done_at[0]), 32'd3);
      check("held_first_dout", dout_at[0], 32'h004);
      check("held_second_at", 32'(done_at[1]), 32'd7);
      check("held_second_dout", dout_at[1], 32'h00C);
    end
    repeat (3) step();

    for (int n = 0; n < 200; n++) begin
      int which, w, s, a;
      logic [1:0] m;
      logic [15:0] d;
      which = int'($urandom_range(0, 1));
      w = (which == 0) ? 9 : 16;
      s = (which == 0) ? 1 : 4;
      a = int'($urandom_range(0, (which == 0) ? 15 : 31));
      m = 2'($urandom);
      d = 16'($urandom);
      if (which == 0) d[15:9] = '0;
      run_op(which, m, a, d, got, lat, bcnt);
      check($sformatf("rnd%0d_dout w%0d m%0d a%0d d%0h", n, w, m, a, d), got, model(w, m, a, d));
      check($sformatf("rnd%0d_lat", n), 32'(lat), 32'(lat_model(w, s, a)));
      repeat ($urandom_range(0, 2)) step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
